rgcp_rr_arbiter: RTL
====================

// Module: rgcp_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single-bit output line b among the four requesters r, c, g, p.
//  It replaces the static 4-input mux select with a sequenced owner: one requester at a time drives b.
//  Ownership lasts until the owner releases or a hold limit expires.
//  Sits between the four r/c/g/p sources and the shared b consumer.
// PARAMETERS
//  HOLD_MAX  8  max cycles one owner may hold b; legal range 1..2**CNT_W-1
//  CNT_W     4  width of the hold counter
// PORTS
//  clk    in   1  single clock, rising edge
//  rst_n  in   1  reset, asynchronous, active-low
//  req    in   4  request lines; bit0=r, bit1=c, bit2=g, bit3=p
//  dat    in   4  data bits, same bit order as req
//  done   in   4  release strobe from the owner, same bit order; ignored for non-owners
//  gnt    out  4  one-hot grant, registered; 0 when no owner
//  sel    out  2  index of current or last owner, registered
//  b      out  1  shared line: dat[sel] while in OWN, else 0 (combinational from dat)
//  busy   out  1  1 while in OWN or GAP
//  tout   out  1  one-cycle pulse when a grant is revoked by hold expiry
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE, gnt=0, sel=0, ptr=0, cnt=0, tout=0, busy=0, b=0.
//    - All outputs take effect immediately, even mid-grant.
//  - States: IDLE, OWN, GAP.
//  - IDLE:
//    - If req!=0, choose winner w = first set req bit scanning ptr, ptr+1, ... mod 4.
//    - Next edge: gnt=1<<w, sel=w, ptr=(w+1) mod 4, cnt=0, state=OWN.
//    - Latency: req sampled at edge N -> gnt visible after edge N+1.
//    - If req==0, stay in IDLE; all outputs hold.
//  - OWN:
//    - cnt increments each cycle.
//    - Release condition: done[sel]=1, or req[sel]=0, or cnt==HOLD_MAX-1.
//    - On release: gnt=0, state=GAP.
//    - tout=1 for that one edge only when expiry is the sole cause; done or req-drop wins over expiry (tout=0).
//  - GAP:
//    - Exactly one cycle with gnt=0 and b=0 (bus turnaround), then IDLE.
//    - A request present in GAP is arbitrated on the following IDLE cycle.
//    - Minimum spacing between grants is therefore 2 idle cycles.
//  - Fairness:
//    - ptr advances past each winner, so a continuously requesting set is served r, c, g, p, r, ...
//    - A single lone requester is re-granted after every GAP/IDLE pair.
//  - Boundaries:
//    - HOLD_MAX=1: the owner gets exactly one OWN cycle; tout=1 unless done or req-drop occurs in that cycle.
//    - cnt never wraps: it is cleared on every grant and saturates at HOLD_MAX-1.
//    - Simultaneous requests: resolved purely by ptr, with no fixed priority.
//    - done from non-owners: ignored in every state.
//    - sel holds its value in IDLE and GAP.
//    - gnt is always one-hot or zero.
// STRUCTURE
//  - Shared package rgcp_pkg:
//    - typedef state_t {IDLE, OWN, GAP}
//    - localparams NREQ=4, IDX_R=0, IDX_C=1, IDX_G=2, IDX_P=3
//  - Sub-module rr_pick (combinational):
//    - Inputs: req[3:0], ptr[1:0].
//    - Outputs: vld, idx[1:0] (rotate, then priority-encode).
//  - Top level: FSM, ptr/sel/cnt registers, tout flop, b output mux.
// TESTING
//  1. Reset hold: rst_n=0 with req=4'b1111 -> gnt=0, b=0, busy=0.
//     Release rst_n -> gnt=0001 after 1 edge.
//  2. Round robin: req=4'b1111, done pulses the owner 2 cycles after each grant.
//     -> gnt sequence 0001, 0010, 0100, 1000, 0001, separated by 1 GAP and 1 IDLE cycle.
//  3. Expiry: HOLD_MAX=8, req=0100 held, done=0.
//     -> gnt=0100 for exactly 8 cycles, tout pulses once, GAP, then re-grant 0100.
//  4. Data path: owner c (sel=1) with dat toggling 1,0,1 -> b follows 1,0,1.
//     dat[0] toggling meanwhile -> b is unaffected.
//  5. Collision: done[sel] and expiry in the same cycle -> release, tout=0.
//     A done pulse on a non-owner bit -> no effect.
//  6. Async reset mid-OWN: drop rst_n between clock edges while gnt=1000.
//     -> gnt=0, sel=0, and ptr=0 immediately; the next grant goes to r if req[0]=1.

Source files
------------

// File: rtl/rgcp_pkg.sv
// Shared types and constants for the r/c/g/p round-robin arbiter.
package rgcp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int NREQ  = 4;
    localparam int IDX_R = 0;
    localparam int IDX_C = 1;
    localparam int IDX_G = 2;
    localparam int IDX_P = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then map the offset back to an absolute index.
module rr_pick
    import rgcp_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic            vld,
    output logic [1:0]      idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [1:0]        off;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        off = 2'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = 2'(i);
        end
        vld = |req;
        idx = ptr + off;
    end

endmodule

// File: rtl/rgcp_rr_arbiter.sv
// Round-robin owner of the shared line b among requesters r, c, g, p.
// Ownership ends on done, request drop, or hold expiry; one GAP cycle follows.
//
//  state | meaning
//  IDLE  | no owner, arbitrate pending requests
//  OWN   | sel drives b, hold counter running
//  GAP   | one-cycle bus turnaround, b forced low
module rgcp_rr_arbiter
    import rgcp_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] dat,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      sel,
    output logic            b,
    output logic            busy,
    output logic            tout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [1:0]        sel_q;
    logic [1:0]        ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              tout_q;

    logic              pick_vld;
    logic [1:0]        pick_idx;
    logic              own_rel;
    logic              own_exp;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    // Expiry only counts as the cause when the owner neither released nor dropped.
    assign own_rel = done[sel_q] | ~req[sel_q];
    assign own_exp = (cnt_q == CNT_LAST);
    assign cnt_d   = own_exp ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            tout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q   <= NREQ'(1) << pick_idx;
                        sel_q   <= pick_idx;
                        ptr_q   <= pick_idx + 2'd1;
                        cnt_q   <= '0;
                        state_q <= OWN;
                    end
                end
                OWN: begin
                    cnt_q <= cnt_d;
                    if (own_rel || own_exp) begin
                        gnt_q   <= '0;
                        tout_q  <= own_exp & ~own_rel;
                        state_q <= GAP;
                    end
                end
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign tout = tout_q;
    assign busy = (state_q != IDLE);
    assign b    = (state_q == OWN) ? dat[sel_q] : 1'b0;

endmodule
